// File: rtl/led_scan_pkg.sv
// Shared types and constants for the 8-digit 7-segment scan controller.
// The digit word carries the one-hot digit select in the high byte and the segment pattern in the low byte.
package led_scan_pkg;

  localparam int SEG_W  = 8;
  localparam int DIGITS = 8;
  localparam int WORD_W = 16;
  localparam int DIG_W  = $clog2(DIGITS);

  localparam logic [WORD_W-1:0] BLANK_WORD = '0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    ON_HOLD,
    BLANK_SHIFT,
    BLANK_LATCH,
    OFF_HOLD
  } state_e;

  function automatic logic [WORD_W-1:0] digit_word(input logic [DIG_W-1:0] d,
                                                   input logic [SEG_W-1:0] seg);
    logic [DIGITS-1:0] sel;
    sel    = '0;
    sel[d] = 1'b1;
    return {sel, seg};
  endfunction

endpackage

// File: rtl/shift595_tx.sv
// Serialises one 16-bit word LSB first into a 595-style chain, then pulses rclk.
// shift_done marks the last shift cycle and done marks the last latch cycle.
module shift595_tx
  import led_scan_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  output logic              sclk,
  output logic              rclk,
  output logic              serial_data,
  output logic              shift_done,
  output logic              done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WORD_W);

  logic [WORD_W-1:0] word_q, word_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              shifting_q, shifting_d;
  logic              latching_q, latching_d;
  logic              sclk_q, sclk_d;
  logic              rclk_q, rclk_d;
  logic              sd_q, sd_d;
  logic              cnt_last;

  assign cnt_last   = (cnt_q == CW'(CLK_DIV - 1));
  assign shift_done = shifting_q & sclk_q & cnt_last & (bit_q == BW'(WORD_W - 1));
  assign done       = latching_q & cnt_last;

  always_comb begin
    word_d     = word_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    shifting_d = shifting_q;
    latching_d = latching_q;
    sclk_d     = sclk_q;
    rclk_d     = rclk_q;
    sd_d       = sd_q;
    if (start) begin
      word_d     = word;
      bit_d      = '0;
      cnt_d      = '0;
      shifting_d = 1'b1;
      latching_d = 1'b0;
      sclk_d     = 1'b0;
      rclk_d     = 1'b0;
      sd_d       = word[0];
    end else if (shifting_q) begin
      if (!cnt_last) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          // Data only moves on the falling half so it is stable across the whole high phase.
          sclk_d = 1'b0;
          if (bit_q == BW'(WORD_W - 1)) begin
            shifting_d = 1'b0;
            latching_d = 1'b1;
            rclk_d     = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
            sd_d  = word_q[bit_d];
          end
        end
      end
    end else if (latching_q) begin
      if (!cnt_last) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d      = '0;
        latching_d = 1'b0;
        rclk_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q     <= '0;
      bit_q      <= '0;
      cnt_q      <= '0;
      shifting_q <= 1'b0;
      latching_q <= 1'b0;
      sclk_q     <= 1'b0;
      rclk_q     <= 1'b0;
      sd_q       <= 1'b0;
    end else begin
      word_q     <= word_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      shifting_q <= shifting_d;
      latching_q <= latching_d;
      sclk_q     <= sclk_d;
      rclk_q     <= rclk_d;
      sd_q       <= sd_d;
    end
  end

  assign sclk        = sclk_q;
  assign rclk        = rclk_q;
  assign serial_data = sd_q;

endmodule

// File: rtl/led_scan_controller.sv
// Multiplexes a double-buffered 8-digit segment image onto the 7-segment Pmod shift-register chain.
// Brightness is an on/blank split of each digit's dwell time.
module led_scan_controller
  import led_scan_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DWELL   = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  input  logic [3:0] brightness,
  output logic       sclk,
  output logic       rclk,
  output logic       srclr_n,
  output logic       serial_data,
  output logic       frame_start,
  output logic       busy
);

  localparam int HW   = $clog2(DWELL);
  localparam int DW16 = DWELL / 16;

  state_e             state_q, state_d;
  logic [DIG_W-1:0]   digit_q, digit_d;
  logic [3:0]         b_q, b_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               stop_q, stop_d;
  logic               pending_q;
  logic               frame_start_q, busy_q, srclr_q;
  logic [SEG_W-1:0]   shadow_q [DIGITS];
  logic [SEG_W-1:0]   active_q [DIGITS];

  logic               apply_commit;
  logic               tx_start, tx_shift_done, tx_done;
  logic [WORD_W-1:0]  tx_word;
  int                 on_t, off_t;

  assign on_t  = (int'(b_q) + 1) * DW16;
  assign off_t = DWELL - on_t;

  shift595_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (tx_start),
    .word       (tx_word),
    .sclk       (sclk),
    .rclk       (rclk),
    .serial_data(serial_data),
    .shift_done (tx_shift_done),
    .done       (tx_done)
  );

  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    b_d          = b_q;
    hold_d       = hold_q;
    stop_d       = stop_q;
    tx_start     = 1'b0;
    tx_word      = BLANK_WORD;
    apply_commit = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          digit_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // The committed image takes effect in this very cycle, so digit 0 reads straight from shadow.
        apply_commit = (digit_q == '0) && pending_q;
        tx_word      = digit_word(digit_q, apply_commit ? shadow_q[digit_q] : active_q[digit_q]);
        tx_start     = 1'b1;
        b_d          = brightness;
        stop_d       = 1'b0;
        state_d      = SHIFT;
      end
      SHIFT: if (tx_shift_done) state_d = LATCH;
      LATCH: begin
        if (tx_done) begin
          hold_d  = HW'(on_t - 1);
          state_d = ON_HOLD;
        end
      end
      ON_HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
        end else if (b_q != 4'hF) begin
          tx_start = 1'b1;
          state_d  = BLANK_SHIFT;
        end else begin
          digit_d = digit_q + DIG_W'(1);
          if (enable) begin
            state_d = LOAD;
          end else begin
            tx_start = 1'b1;
            stop_d   = 1'b1;
            state_d  = BLANK_SHIFT;
          end
        end
      end
      BLANK_SHIFT: if (tx_shift_done) state_d = BLANK_LATCH;
      BLANK_LATCH: begin
        if (tx_done) begin
          if (stop_q) begin
            state_d = IDLE;
          end else begin
            hold_d  = HW'(off_t - 1);
            state_d = OFF_HOLD;
          end
        end
      end
      OFF_HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
        end else begin
          digit_d = digit_q + DIG_W'(1);
          state_d = enable ? LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      digit_q       <= '0;
      b_q           <= '0;
      hold_q        <= '0;
      stop_q        <= 1'b0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      srclr_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      b_q           <= b_d;
      hold_q        <= hold_d;
      stop_q        <= stop_d;
      // A commit landing on the applying cycle stays pending for the following frame.
      pending_q     <= commit | (pending_q & ~apply_commit);
      frame_start_q <= (state_d == LOAD) && (digit_d == '0);
      busy_q        <= (state_d != IDLE);
      srclr_q       <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (wr_en) shadow_q[wr_addr] <= wr_data;
      if (apply_commit) begin
        for (int i = 0; i < DIGITS; i++) active_q[i] <= shadow_q[i];
      end
    end
  end

  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign srclr_n     = srclr_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// Bench for led_scan_controller: captures every latched chain word and compares content and spacing
// against a frame/slot-level model of the display image, commits and brightness.
`timescale 1ns/1ps
module tb_led_scan_controller;

  localparam int CD = 1;
  localparam int DW = 64;

  logic       clk = 1'b0;
  logic       rst_n, enable, wr_en, commit;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] brightness;
  logic       sclk, rclk, srclr_n, serial_data, frame_start, busy;

  always #5 clk = ~clk;

  led_scan_controller #(.CLK_DIV(CD), .DWELL(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .brightness (brightness),
    .sclk       (sclk),
    .rclk       (rclk),
    .srclr_n    (srclr_n),
    .serial_data(serial_data),
    .frame_start(frame_start),
    .busy       (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Chain monitor: shift on sclk rise, record word on rclk rise.
  typedef struct {
    logic [15:0] word;
    int          t;
    int          bits;
  } latch_t;

  latch_t      lq[$];
  int          cyc = 0;
  int          frames_seen = 0;
  int          viol = 0;
  logic [15:0] sh = '0;
  int          nbits = 0;
  logic        sclk_p = 1'b0, rclk_p = 1'b0, sd_p = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      sh    = '0;
      nbits = 0;
      lq.delete();
    end else begin
      if (sclk && !sclk_p) begin
        sh = {serial_data, sh[15:1]};
        nbits++;
      end
      if (rclk && !rclk_p) begin
        lq.push_back('{sh, cyc, nbits});
        nbits = 0;
      end
      if (rclk && sclk) viol++;
      if (sclk && (serial_data !== sd_p)) viol++;
      if (frame_start) frames_seen++;
    end
    sclk_p = sclk;
    rclk_p = rclk;
    sd_p   = serial_data;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference model: display image, pending commit, and the expected word/gap sequence per digit slot.
  logic [7:0] m_shadow [8];
  logic [7:0] m_active [8];
  bit         m_pending, m_blank_next, m_have_last;
  int         m_digit, m_b, m_next_gap, m_frames, m_last_t, m_last_digit;

  function automatic int on_cycles(input int b);
    return ((b + 1) * DW) >> 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_pending    = 0;
    m_digit      = 0;
    m_blank_next = 0;
    m_have_last  = 0;
    m_next_gap   = 0;
    m_last_digit = -1;
    m_b          = 15;
  endtask

  task automatic model_idle();
    m_digit      = 0;
    m_blank_next = 0;
    m_have_last  = 0;
  endtask

  task automatic pop(output latch_t e, output bit ok);
    int n;
    n  = 0;
    ok = 0;
    while (lq.size() == 0 && n < 400) begin
      tick();
      n++;
    end
    if (lq.size() == 0) check_eq("latch_timeout", 32'd0, 32'd1);
    else begin
      e  = lq.pop_front();
      ok = 1;
    end
  endtask

  task automatic step();
    latch_t      e;
    bit          ok;
    logic [15:0] exp_w;
    int          gap;
    string       tag;
    if (m_blank_next) begin
      exp_w        = 16'h0000;
      gap          = 33 * CD + on_cycles(m_b);
      m_next_gap   = 1 + 33 * CD + DW - on_cycles(m_b);
      m_blank_next = 0;
      m_last_digit = -1;
      tag          = "word_blank";
    end else begin
      if (m_digit == 0) begin
        m_frames++;
        if (m_pending) begin
          m_active  = m_shadow;
          m_pending = 0;
        end
      end
      exp_w        = {8'(1 << m_digit), m_active[m_digit]};
      gap          = m_next_gap;
      m_b          = int'(brightness);
      m_blank_next = (m_b != 15);
      m_next_gap   = 1 + 33 * CD + DW;
      m_last_digit = m_digit;
      m_digit      = (m_digit + 1) % 8;
      tag          = $sformatf("word_d%0d", m_last_digit);
    end
    pop(e, ok);
    if (ok) begin
      $display("latch t=%0d word=%04h bits=%0d exp=%04h", e.t, e.word, e.bits, exp_w);
      check_eq(tag, e.word, exp_w);
      check_eq("bits_per_word", e.bits, 16);
      if (m_have_last) check_eq("latch_gap", e.t - m_last_t, gap);
      m_last_t    = e.t;
      m_have_last = 1;
    end
  endtask

  task automatic step_to_digit(input int d);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (m_last_digit != d && n < 40);
  endtask

  task automatic do_write(input int a, input logic [7:0] d, input bit c);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    commit  = c;
    tick();
    wr_en  = 1'b0;
    commit = 1'b0;
    m_shadow[a] = d;
    if (c) m_pending = 1;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit    = 1'b0;
    m_pending = 1;
  endtask

  task automatic expect_idle(input string tag);
    repeat (300) tick();
    check_eq({tag, "_no_extra_latch"}, lq.size(), 0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    model_idle();
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    enable     = 1'b0;
    wr_en      = 1'b0;
    commit     = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    brightness = 4'd15;
    m_frames   = 0;
    model_reset();
    repeat (3) tick();
    check_eq("rst_sclk", sclk, 1'b0);
    check_eq("rst_rclk", rclk, 1'b0);
    check_eq("rst_sdata", serial_data, 1'b0);
    check_eq("rst_srclr_n", srclr_n, 1'b0);
    check_eq("rst_frame_start", frame_start, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    check_eq("srclr_after_release", srclr_n, 1'b1);
    check_eq("busy_idle", busy, 1'b0);

    // Full brightness, digit 0 = A5, two frames.
    do_write(0, 8'hA5, 0);
    for (int i = 1; i < 8; i++) do_write(i, 8'($urandom), 0);
    do_commit();
    enable = 1'b1;
    for (int i = 0; i < 16; i++) step();
    check_eq("busy_running", busy, 1'b1);

    // 4/16 duty: 16 on, 48 off.
    brightness = 4'd3;
    for (int i = 0; i < 16; i++) step();

    // Uncommitted write is invisible until a commit reaches a frame start.
    step_to_digit(1);
    do_write(5, 8'hFF, 0);
    step_to_digit(3);
    do_commit();
    step_to_digit(7);
    step_to_digit(5);

    // Write and commit in the same cycle.
    step_to_digit(4);
    do_write(2, 8'($urandom), 1);
    step_to_digit(3);

    // Random writes, commits and brightness changes.
    for (int i = 0; i < 60; i++) begin
      step();
      if (m_last_digit >= 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: do_write($urandom_range(0, 7), 8'($urandom), 0);
          4:          do_commit();
          5:          do_write($urandom_range(0, 7), 8'($urandom), 1);
          6, 7:       brightness = 4'($urandom_range(0, 15));
          default:    ;
        endcase
      end
    end

    // Stop during digit 6 with partial duty: the normal blank is the last word.
    step_to_digit(4);
    brightness = 4'd7;
    step_to_digit(6);
    enable = 1'b0;
    step();
    expect_idle("stop_dim");
    check_eq("frame_start_count", frames_seen, m_frames);

    // Stop during digit 6 at full duty: an extra blank word is shifted before idling.
    brightness = 4'd15;
    enable     = 1'b1;
    step_to_digit(6);
    enable       = 1'b0;
    m_blank_next = 1;
    step();
    expect_idle("stop_full");

    // Reset in the middle of a shift, then restart with an empty image.
    enable = 1'b1;
    n = 0;
    while (sclk !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check_eq("reached_shift", sclk, 1'b1);
    rst_n = 1'b0;
    tick();
    check_eq("midrst_sclk", sclk, 1'b0);
    check_eq("midrst_rclk", rclk, 1'b0);
    check_eq("midrst_sdata", serial_data, 1'b0);
    check_eq("midrst_srclr_n", srclr_n, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    check_eq("midrst_srclr_release", srclr_n, 1'b1);
    for (int i = 0; i < 8; i++) step();

    check_eq("sclk_rclk_sdata_rules", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
